// File: rtl/btn_enc_pkg.sv
// Shared constants, FSM state type and small helpers for the button encoder.
package btn_enc_pkg;

  localparam int unsigned N_BTN               = 4;
  localparam int unsigned N_SW                = 2;
  localparam int unsigned IDX_W               = 2;
  localparam int unsigned CODE_W              = N_SW + IDX_W;
  localparam int unsigned CNT_RISE_W          = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1250000;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_e;

  // Highest set bit wins; returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] hi_idx(input logic [N_BTN-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [CNT_RISE_W-1:0] pop_cnt(input logic [N_BTN-1:0] v);
    logic [CNT_RISE_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      r = r + CNT_RISE_W'(v[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit two-flop synchroniser followed by a counter-based debouncer.
module btn_debounce
  import btn_enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/btn_priority_encoder.sv
// Debounces buttons, priority-encodes new press edges and latches them with the
// synchronised switch value into a registered code plus a capture strobe.
module btn_priority_encoder
  import btn_enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn,
  input  logic [N_SW-1:0]   sw,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              code_strobe,
  output logic              held,
  output logic              multi_press
);

  logic [N_BTN-1:0]  stable;
  logic [N_BTN-1:0]  stable_dly_q;
  logic [N_SW-1:0]   sw_meta_q;
  logic [N_SW-1:0]   sw_sync_q;
  logic [N_BTN-1:0]  rise;
  logic [N_BTN-1:0]  other_rise;
  logic [IDX_W-1:0]  idx;
  logic              any_rise;
  logic [CNT_RISE_W-1:0] n_rise;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              strobe_q, strobe_d;
  logic              held_q, held_d;
  logic              multi_q, multi_d;
  logic [IDX_W-1:0]  cap_q, cap_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn[g]),
      .stable_o(stable[g])
    );
  end

  assign rise       = stable & ~stable_dly_q;
  assign other_rise = rise & ~(N_BTN'(1) << cap_q);
  assign any_rise   = |rise;
  assign idx        = hi_idx(rise);
  assign n_rise     = pop_cnt(rise);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    held_d   = held_q;
    multi_d  = multi_q;
    cap_d    = cap_q;
    case (state_q)
      IDLE: begin
        if (any_rise) begin
          code_d   = {sw_sync_q, idx};
          strobe_d = 1'b1;
          valid_d  = 1'b1;
          held_d   = 1'b1;
          cap_d    = idx;
          multi_d  = (n_rise > CNT_RISE_W'(1));
          state_d  = PRESSED;
        end
      end
      PRESSED: begin
        // Release of the captured button takes precedence over any new edge.
        if (!stable[cap_q]) begin
          held_d  = 1'b0;
          state_d = IDLE;
        end else if (|other_rise) begin
          multi_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= '0;
      valid_q      <= 1'b0;
      strobe_q     <= 1'b0;
      held_q       <= 1'b0;
      multi_q      <= 1'b0;
      cap_q        <= '0;
      stable_dly_q <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      strobe_q     <= strobe_d;
      held_q       <= held_d;
      multi_q      <= multi_d;
      cap_q        <= cap_d;
      stable_dly_q <= stable;
      sw_meta_q    <= sw;
      sw_sync_q    <= sw_meta_q;
    end
  end

  assign code        = code_q;
  assign code_valid  = valid_q;
  assign code_strobe = strobe_q;
  assign held        = held_q;
  assign multi_press = multi_q;

endmodule

// File: tb/tb_btn_priority_encoder.sv
// Directed bench for btn_priority_encoder with a short debounce window.
module tb_btn_priority_encoder;

  localparam int unsigned DEB = 4;
  localparam int unsigned LAT = 3 + DEB;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [1:0] sw;
  logic [3:0] code;
  logic       code_valid;
  logic       code_strobe;
  logic       held;
  logic       multi_press;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] sw;
    logic [3:0] exp_code;
    logic       exp_multi;
  } vec_t;

  vec_t vecs[4];

  btn_priority_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .sw         (sw),
    .code       (code),
    .code_valid (code_valid),
    .code_strobe(code_strobe),
    .held       (held),
    .multi_press(multi_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && code_strobe) strobe_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges from the drive point until the strobe shows, then checks it is one cycle wide.
  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    while (n < 40 && !code_strobe) begin
      tick(1);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(LAT));
    tick(1);
    check({name, "_pulse"}, 32'(code_strobe), 32'(0));
  endtask

  task automatic wait_release(input string name);
    int n;
    n = 0;
    while (n < 40 && held) begin
      tick(1);
      n++;
    end
    check({name, "_rel_latency"}, 32'(n), 32'(LAT));
  endtask

  task automatic check_outs(input string name, input logic [3:0] c, input logic v,
                            input logic h, input logic m);
    check({name, "_code"}, 32'(code), 32'(c));
    check({name, "_valid"}, 32'(code_valid), 32'(v));
    check({name, "_held"}, 32'(held), 32'(h));
    check({name, "_multi"}, 32'(multi_press), 32'(m));
  endtask

  initial begin
    int base;
    vecs[0] = '{btn: 4'b0100, sw: 2'b01, exp_code: 4'b0110, exp_multi: 1'b0};
    vecs[1] = '{btn: 4'b1010, sw: 2'b10, exp_code: 4'b1011, exp_multi: 1'b1};
    vecs[2] = '{btn: 4'b0001, sw: 2'b11, exp_code: 4'b1100, exp_multi: 1'b0};
    vecs[3] = '{btn: 4'b1111, sw: 2'b00, exp_code: 4'b0011, exp_multi: 1'b1};

    rst = 1'b1;
    btn = '0;
    sw  = '0;
    #2;
    check_outs("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    check("reset_strobe", 32'(code_strobe), 32'(0));
    tick(3);
    rst = 1'b0;

    // Bouncing button never settles long enough to be captured.
    base = strobe_cnt;
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      tick(2);
    end
    btn[0] = 1'b0;
    tick(15);
    check("bounce_strobes", 32'(strobe_cnt - base), 32'(0));
    check("bounce_code", 32'(code), 32'(0));
    check("bounce_valid", 32'(code_valid), 32'(0));

    for (int i = 0; i < 4; i++) begin
      sw  = vecs[i].sw;
      btn = vecs[i].btn;
      wait_strobe($sformatf("vec%0d", i));
      check_outs($sformatf("vec%0d", i), vecs[i].exp_code, 1'b1, 1'b1, vecs[i].exp_multi);
      btn = '0;
      wait_release($sformatf("vec%0d", i));
      check($sformatf("vec%0d_code_kept", i), 32'(code), 32'(vecs[i].exp_code));
      tick(4);
    end

    // Second press while holding, switch change, release of the captured button first.
    sw  = 2'b10;
    btn = 4'b1000;
    wait_strobe("hold3");
    check_outs("hold3", 4'b1011, 1'b1, 1'b1, 1'b0);
    base = strobe_cnt;
    tick(3);
    btn = 4'b1001;
    tick(10);
    sw = 2'b01;
    tick(3);
    check("press0_multi", 32'(multi_press), 32'(1));
    btn = 4'b0001;
    wait_release("rel3");
    tick(20);
    check("rel3_strobes", 32'(strobe_cnt - base), 32'(0));
    check_outs("rel3", 4'b1011, 1'b1, 1'b0, 1'b1);

    btn = 4'b0000;
    tick(10);
    sw  = 2'b11;
    btn = 4'b0001;
    wait_strobe("repress0");
    check_outs("repress0", 4'b1100, 1'b1, 1'b1, 1'b0);
    btn = 4'b0000;
    wait_release("repress0");
    tick(4);

    // Asynchronous reset in the middle of a press; the held button is re-captured.
    sw  = 2'b01;
    btn = 4'b0100;
    wait_strobe("pre_rst");
    tick(2);
    rst = 1'b1;
    #1;
    check_outs("async_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(3);
    rst = 1'b0;
    wait_strobe("post_rst");
    check_outs("post_rst", 4'b0110, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
